// File: rtl/branch_cond_unit.sv
// rtl/branch_cond_unit.sv - iterative MSB-first slice comparator producing branch taken/eq/lt
module branch_cond_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_taken,
    output logic             resp_eq,
    output logic             resp_lt,
    output logic             resp_illegal
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             taken_q, taken_d;

    logic [SLICE-1:0] slice_a, slice_b;
    logic             slice_lt;
    logic             accept;

    // Branch condition from the final compare flags; illegal opcodes never branch.
    function automatic logic taken_of(input logic [2:0] op, input logic eq, input logic lt);
        case (op)
            3'b000:  taken_of = eq;
            3'b001:  taken_of = !eq;
            3'b010:  taken_of = lt | eq;
            3'b011:  taken_of = !lt & !eq;
            3'b100:  taken_of = lt;
            3'b101:  taken_of = !lt;
            default: taken_of = 1'b0;
        endcase
    endfunction

    assign req_ready    = (state_q == S_IDLE) && reset;
    assign resp_valid   = (state_q == S_DONE);
    assign resp_taken   = taken_q;
    assign resp_eq      = eq_q;
    assign resp_lt      = lt_q;
    assign resp_illegal = illegal_q;
    assign accept       = req_valid && req_ready && !flush;

    // Select the current slice (MSB first); only the top slice carries the sign.
    always_comb begin
        slice_a  = a_q[(N - int'(idx_q)) * SLICE - 1 -: SLICE];
        slice_b  = b_q[(N - int'(idx_q)) * SLICE - 1 -: SLICE];
        slice_lt = (idx_q == '0) ? ($signed(slice_a) < $signed(slice_b)) : (slice_a < slice_b);
    end

    // Next-state and result-register logic; flush forces IDLE and blocks acceptance.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        taken_d   = taken_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d       = req_a;
                    // Only beq/bne compare against rt; the rest compare against zero.
                    b_d       = (req_op[2:1] == 2'b00) ? req_b : '0;
                    op_d      = req_op;
                    idx_d     = '0;
                    illegal_d = (req_op[2:1] == 2'b11);
                    state_d   = S_EVAL;
                end
            end
            S_EVAL: begin
                if (slice_a != slice_b) begin
                    eq_d    = 1'b0;
                    lt_d    = slice_lt;
                    taken_d = taken_of(op_q, 1'b0, slice_lt);
                    state_d = S_DONE;
                end else if (idx_q == IW'(N - 1)) begin
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    taken_d = taken_of(op_q, 1'b1, 1'b0);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // State and operand registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            taken_q   <= taken_d;
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// tb/tb_branch_cond_unit.sv - randomized self-checking bench for branch_cond_unit
module tb_branch_cond_unit;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [2:0]       req_op = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             resp_taken;
    logic             resp_eq;
    logic             resp_lt;
    logic             resp_illegal;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_cond_unit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_taken   (resp_taken),
        .resp_eq      (resp_eq),
        .resp_lt      (resp_lt),
        .resp_illegal (resp_illegal)
    );

    // Reference: full-width signed compare; latency is set by the leading differing bit.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op,
                         output logic eq, output logic lt, output logic taken, output logic ill,
                         output int lat);
        logic [WIDTH-1:0] bp;
        logic [WIDTH-1:0] diff;
        int hi;
        bp   = (op == 3'd0 || op == 3'd1) ? b : '0;
        eq   = (a == bp);
        lt   = ($signed(a) < $signed(bp));
        ill  = (op >= 3'd6);
        diff = a ^ bp;
        hi   = -1;
        for (int i = 0; i < WIDTH; i++) if (diff[i]) hi = i;
        lat  = (hi < 0) ? N : ((WIDTH - 1 - hi) / SLICE + 1);
        case (op)
            3'd0: taken = eq;
            3'd1: taken = !eq;
            3'd2: taken = lt || eq;
            3'd3: taken = !lt && !eq;
            3'd4: taken = lt;
            3'd5: taken = !lt;
            default: taken = 1'b0;
        endcase
    endtask

    // Present a request at a negedge and let it be accepted; then scramble the inputs.
    task automatic start_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op,
                             input string name);
        @(negedge clk);
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
    endtask

    // Called at the negedge after the accept edge: measure latency, check flags, hold, then hand off.
    task automatic wait_check(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op,
                              input int hold, input logic handoff, input string name);
        logic eq, lt, taken, ill;
        int lat, got;
        model(a, b, op, eq, lt, taken, ill, lat);
        got = 0;
        while (resp_valid !== 1'b1 && got < 10) begin
            @(posedge clk);
            got++;
            @(negedge clk);
        end
        tests++;
        if (got != lat || resp_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s latency: got %0d (valid %b) want %0d", name, got, resp_valid, lat);
        end
        tests++;
        if ({resp_taken, resp_eq, resp_lt, resp_illegal} !== {taken, eq, lt, ill}) begin
            fails++;
            $display("FAIL %s flags t/e/l/i: got %b%b%b%b want %b%b%b%b", name,
                     resp_taken, resp_eq, resp_lt, resp_illegal, taken, eq, lt, ill);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            tests++;
            if ({resp_valid, req_ready, resp_taken, resp_eq, resp_lt, resp_illegal} !==
                {1'b1, 1'b0, taken, eq, lt, ill}) begin
                fails++;
                $display("FAIL %s hold v/r/t/e/l/i: got %b%b%b%b%b%b want 10%b%b%b%b", name,
                         resp_valid, req_ready, resp_taken, resp_eq, resp_lt, resp_illegal,
                         taken, eq, lt, ill);
            end
        end
        if (handoff) begin
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
            tests++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                fails++;
                $display("FAIL %s handoff valid/ready: got %b/%b want 0/1", name, resp_valid, req_ready);
            end
        end
    endtask

    task automatic run_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op,
                           input int hold, input string name);
        start_req(a, b, op, name);
        wait_check(a, b, op, hold, 1'b1, name);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({req_ready, resp_valid, resp_taken, resp_eq, resp_lt, resp_illegal} !== 6'b0) begin
            fails++;
            $display("FAIL reset_state r/v/t/e/l/i: got %b%b%b%b%b%b want 000000",
                     req_ready, resp_valid, resp_taken, resp_eq, resp_lt, resp_illegal);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release ready/valid: got %b/%b want 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_directed();
        run_one(32'h12345678, 32'h12345678, 3'd0, 0, "beq_equal");
        run_one(32'h80000000, 32'h00000000, 3'd0, 0, "beq_signed");
        run_one(32'h80000000, 32'h00000000, 3'd1, 0, "bne_signed");
        run_one(32'hFFFFFFFF, 32'hDEADBEEF, 3'd4, 0, "bltz_neg");
        run_one(32'h00000000, 32'hDEADBEEF, 3'd5, 0, "bgez_zero");
        run_one(32'h00000001, 32'hDEADBEEF, 3'd3, 0, "bgtz_one");
        run_one(32'h00000100, 32'hDEADBEEF, 3'd2, 0, "blez_256");
        run_one(32'h00000000, 32'h00000000, 3'd6, 0, "illegal_110");
        run_one(32'h7FFFFFFF, 32'h7FFFFF00, 3'd1, 1, "bne_last_slice");
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic [2:0] op;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) == 0) a = a >> ($urandom_range(0, 4) * SLICE);
            b = a;
            if ($urandom_range(0, 3) != 0) b = b ^ (WIDTH'($urandom_range(1, 255)) << ($urandom_range(0, N - 1) * SLICE));
            run_one(a, b, op, $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_back_to_back();
        start_req(32'hA5A5A5A5, 32'hA5A5A5A5, 3'd0, "bp_first");
        wait_check(32'hA5A5A5A5, 32'hA5A5A5A5, 3'd0, 0, 1'b0, "bp_first");
        req_a = 32'h00000001; req_b = 32'h00000002; req_op = 3'd0; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            tests++;
            if ({resp_valid, req_ready, resp_taken, resp_eq, resp_lt} !== 5'b10110) begin
                fails++;
                $display("FAIL backpressure v/r/t/e/l: got %b%b%b%b%b want 10110",
                         resp_valid, req_ready, resp_taken, resp_eq, resp_lt);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release valid/ready: got %b/%b want 0/1", resp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_second_accept ready: got %b want 0", req_ready);
        end
        req_a = $urandom; req_b = $urandom;
        wait_check(32'h00000001, 32'h00000002, 3'd0, 0, 1'b1, "bp_second");
    endtask

    task automatic test_flush();
        start_req(32'h11223344, 32'h11223344, 3'd0, "flush_victim");
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        req_a = 32'h80000000; req_b = 32'h00000000; req_op = 3'd1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_idle valid/ready: got %b/%b want 0/1", resp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_reaccept ready: got %b want 0", req_ready);
        end
        wait_check(32'h80000000, 32'h00000000, 3'd1, 0, 1'b1, "flush_next");
    endtask

    task automatic test_reset_mid();
        start_req(32'h55667788, 32'h55667788, 3'd0, "reset_victim");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            tests++;
            if ({req_ready, resp_valid, resp_taken, resp_eq, resp_lt, resp_illegal} !== 6'b0) begin
                fails++;
                $display("FAIL reset_mid r/v/t/e/l/i: got %b%b%b%b%b%b want 000000",
                         req_ready, resp_valid, resp_taken, resp_eq, resp_lt, resp_illegal);
            end
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_release ready/valid: got %b/%b want 1/0", req_ready, resp_valid);
        end
        run_one(32'hFFFFFF00, 32'hFFFFFFFF, 3'd0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
